// File: rtl/riscv_pkg.sv
// Shared memory-access encodings and lane helpers used by the load/store path
// and by the writeback stage.
package riscv_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  // Size code 2'b11 falls through to the word case everywhere.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_enables = 4'b0001 << off;
      SZ_HALF: byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: store_lanes = {4{data[7:0]}};
      SZ_HALF: store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational extract-and-extend of a read word by byte offset, size and
// signedness.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = 8'(rdata >> {off, 3'b000});
    lane_half = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{~load_unsigned & lane_byte[7]}}, lane_byte};
      SZ_HALF: data = {{16{~load_unsigned & lane_half[15]}}, lane_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: accepts one decoded memory op at a time, runs the data-bus
// request/ready handshake and returns extended load data to writeback.
module lsu_mem_if
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              load_req_in,
  input  logic              mem_wr_req_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic              misaligned_in,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data_in,
  output logic              dmem_req_out,
  output logic              dmem_we_out,
  output logic [ADDR_W-1:0] dmem_addr_out,
  output logic [3:0]        dmem_be_out,
  output logic [31:0]       dmem_wdata_out,
  input  logic              dmem_ready_in,
  input  logic [31:0]       dmem_rdata_in,
  output logic              stall_out,
  output logic [31:0]       load_data_out,
  output logic              load_valid_out,
  output logic              bus_error_out
);

  // The counter only has to reach TIMEOUT_CYCLES-1: expiry is detected on the
  // last ready-less WAIT cycle rather than after a further increment.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic             accept;
  logic             timeout_hit;
  logic [31:0]      aligned_data;

  // Handshake: dmem_req_out/we/addr/be/wdata are driven from the accept edge
  // and held constant until the clock edge at which dmem_ready_in is sampled
  // high; that edge completes the access and dmem_req_out drops after it.
  // dmem_ready_in is ignored whenever no request is outstanding.
  assign accept      = (state == LSU_IDLE) & (load_req_in | mem_wr_req_in)
                     & ~misaligned_in & ~flush_in;
  assign stall_out   = ~reset_in & (accept | (state == LSU_WAIT));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

  load_align u_load_align (
    .rdata         (dmem_rdata_in),
    .off           (off_q),
    .size          (size_q),
    .load_unsigned (unsigned_q),
    .data          (aligned_data)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state          <= LSU_IDLE;
      wait_cnt       <= '0;
      off_q          <= 2'b00;
      size_q         <= 2'b00;
      unsigned_q     <= 1'b0;
      dmem_req_out   <= 1'b0;
      dmem_we_out    <= 1'b0;
      dmem_addr_out  <= '0;
      dmem_be_out    <= 4'b0000;
      dmem_wdata_out <= 32'h0;
      load_data_out  <= 32'h0;
      load_valid_out <= 1'b0;
      bus_error_out  <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      bus_error_out  <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            state          <= LSU_WAIT;
            wait_cnt       <= '0;
            off_q          <= addr_in[1:0];
            size_q         <= load_size_in;
            unsigned_q     <= load_unsigned_in;
            dmem_req_out   <= 1'b1;
            dmem_we_out    <= mem_wr_req_in;
            dmem_addr_out  <= {addr_in[ADDR_W-1:2], 2'b00};
            dmem_be_out    <= byte_enables(load_size_in, addr_in[1:0]);
            dmem_wdata_out <= mem_wr_req_in ? store_lanes(load_size_in, store_data_in) : 32'h0;
          end
        end
        LSU_WAIT: begin
          // Ready wins over a simultaneous timeout expiry.
          if (dmem_ready_in) begin
            state        <= LSU_IDLE;
            dmem_req_out <= 1'b0;
            if (!dmem_we_out) begin
              load_data_out  <= aligned_data;
              load_valid_out <= 1'b1;
            end
          end else if (timeout_hit) begin
            state         <= LSU_IDLE;
            dmem_req_out  <= 1'b0;
            bus_error_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: two instances (default timeout and timeout 4) share
// one stimulus stream and are checked every cycle against a transaction model.
module tb_lsu_mem_if;
  import riscv_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic load_req_in = 1'b0, mem_wr_req_in = 1'b0, load_unsigned_in = 1'b0;
  logic misaligned_in = 1'b0, flush_in = 1'b0, dmem_ready_in = 1'b0;
  logic [1:0]  load_size_in = 2'b00;
  logic [31:0] addr_in = 32'h0, store_data_in = 32'h0, dmem_rdata_in = 32'h0;

  logic        req_w[N], we_w[N], stall_w[N], lv_w[N], err_w[N];
  logic [31:0] addr_w[N], wdata_w[N], ld_w[N];
  logic [3:0]  be_w[N];

  int checks = 0;
  int errors = 0;
  int stall_cnt[N], err_cnt[N], lv_cnt[N];

  always #5 clk = ~clk;

  lsu_mem_if dut0 (
    .clk_in(clk), .reset_in(reset_in), .load_req_in(load_req_in), .mem_wr_req_in(mem_wr_req_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in), .misaligned_in(misaligned_in),
    .flush_in(flush_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .dmem_req_out(req_w[0]), .dmem_we_out(we_w[0]), .dmem_addr_out(addr_w[0]),
    .dmem_be_out(be_w[0]), .dmem_wdata_out(wdata_w[0]), .dmem_ready_in(dmem_ready_in),
    .dmem_rdata_in(dmem_rdata_in), .stall_out(stall_w[0]), .load_data_out(ld_w[0]),
    .load_valid_out(lv_w[0]), .bus_error_out(err_w[0])
  );

  lsu_mem_if #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut1 (
    .clk_in(clk), .reset_in(reset_in), .load_req_in(load_req_in), .mem_wr_req_in(mem_wr_req_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in), .misaligned_in(misaligned_in),
    .flush_in(flush_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .dmem_req_out(req_w[1]), .dmem_we_out(we_w[1]), .dmem_addr_out(addr_w[1]),
    .dmem_be_out(be_w[1]), .dmem_wdata_out(wdata_w[1]), .dmem_ready_in(dmem_ready_in),
    .dmem_rdata_in(dmem_rdata_in), .stall_out(stall_w[1]), .load_data_out(ld_w[1]),
    .load_valid_out(lv_w[1]), .bus_error_out(err_w[1])
  );

  function automatic int limit_of(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] model_be(input logic [1:0] sz, input int off);
    if (sz == 2'b00) return 4'(1 << off);
    if (sz == 2'b01) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[7:0];
    h = d[15:0];
    if (sz == 2'b00) return b * 32'h01010101;
    if (sz == 2'b01) return h * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                             input logic [1:0] sz, input logic uns);
    int unsigned v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  logic        m_busy[N], m_req[N], m_we[N], m_lv[N], m_err[N], m_uns[N];
  logic [31:0] m_addr[N], m_wdata[N], m_ld[N];
  logic [3:0]  m_be[N];
  logic [1:0]  m_size[N];
  int          m_off[N], m_waited[N];

  always @(posedge clk or posedge reset_in) begin
    for (int k = 0; k < N; k++) begin
      if (reset_in) begin
        m_busy[k] = 0; m_req[k] = 0; m_we[k] = 0; m_lv[k] = 0; m_err[k] = 0; m_uns[k] = 0;
        m_addr[k] = 0; m_wdata[k] = 0; m_ld[k] = 0; m_be[k] = 0; m_size[k] = 0;
        m_off[k] = 0; m_waited[k] = 0;
      end else begin
        m_lv[k]  = 0;
        m_err[k] = 0;
        if (!m_busy[k]) begin
          if ((load_req_in || mem_wr_req_in) && !misaligned_in && !flush_in) begin
            m_busy[k]   = 1;
            m_waited[k] = 0;
            m_req[k]    = 1;
            m_we[k]     = mem_wr_req_in;
            m_off[k]    = addr_in % 4;
            m_addr[k]   = addr_in - m_off[k];
            m_size[k]   = load_size_in;
            m_uns[k]    = load_unsigned_in;
            m_be[k]     = model_be(load_size_in, m_off[k]);
            m_wdata[k]  = mem_wr_req_in ? model_wdata(load_size_in, store_data_in) : 32'h0;
          end
        end else if (dmem_ready_in) begin
          m_busy[k] = 0;
          m_req[k]  = 0;
          if (!m_we[k]) begin
            m_lv[k] = 1;
            m_ld[k] = model_load(dmem_rdata_in, m_off[k], m_size[k], m_uns[k]);
          end
        end else begin
          m_waited[k]++;
          if (m_waited[k] == limit_of(k)) begin
            m_busy[k] = 0;
            m_req[k]  = 0;
            m_err[k]  = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic exp_stall;
      exp_stall = !reset_in && (m_busy[k] || ((load_req_in || mem_wr_req_in)
                  && !misaligned_in && !flush_in));
      check("req", k, req_w[k], m_req[k]);
      check("stall", k, stall_w[k], exp_stall);
      check("load_valid", k, lv_w[k], m_lv[k]);
      check("bus_error", k, err_w[k], m_err[k]);
      check("load_data", k, ld_w[k], m_ld[k]);
      if (m_req[k]) begin
        check("we", k, we_w[k], m_we[k]);
        check("addr", k, addr_w[k], m_addr[k]);
        check("be", k, be_w[k], m_be[k]);
        check("wdata", k, wdata_w[k], m_wdata[k]);
      end
      if (stall_w[k]) stall_cnt[k]++;
      if (err_w[k])   err_cnt[k]++;
      if (lv_w[k])    lv_cnt[k]++;
    end
  end

  // ---------------- driver ----------------
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  int          stalls;

  // Entered and left #1 after a rising edge; ready comes after `delay` WAIT cycles.
  task automatic access(input logic st, input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                        input int delay);
    int s0;
    s0 = stall_cnt[0];
    mem_wr_req_in = st; load_req_in = ld; load_size_in = sz; load_unsigned_in = uns;
    addr_in = a; store_data_in = d;
    @(posedge clk); #1;
    snap_we = we_w[0]; snap_addr = addr_w[0]; snap_be = be_w[0]; snap_wdata = wdata_w[0];
    mem_wr_req_in = 0; load_req_in = 0;
    addr_in = $urandom; store_data_in = $urandom; load_size_in = 2'($urandom_range(0, 3));
    load_unsigned_in = 1'($urandom_range(0, 1));
    repeat (delay) begin @(posedge clk); #1; end
    dmem_ready_in = 1; dmem_rdata_in = rd;
    @(posedge clk); #1;
    dmem_ready_in = 0; dmem_rdata_in = $urandom;
    stalls = stall_cnt[0] - s0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, l1, s0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check("rst_req", k, req_w[k], 0);
      check("rst_stall", k, stall_w[k], 0);
      check("rst_be", k, be_w[k], 0);
      check("rst_ld", k, ld_w[k], 0);
    end
    reset_in = 0;
    @(posedge clk); #1;

    access(1, 0, SZ_WORD, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    check("sw_we", 0, snap_we, 1);
    check("sw_addr", 0, snap_addr, 32'h100);
    check("sw_be", 0, snap_be, 4'b1111);
    check("sw_wdata", 0, snap_wdata, 32'hDEADBEEF);
    check("sw_stalls", 0, stalls, 2);
    check("sw_no_lv", 0, lv_w[0], 0);

    access(1, 0, SZ_BYTE, 0, 32'h203, 32'h000000A5, 32'h0, 0);
    check("sb_addr", 0, snap_addr, 32'h200);
    check("sb_be", 0, snap_be, 4'b1000);
    check("sb_wdata", 0, snap_wdata, 32'hA5A5A5A5);

    access(0, 1, SZ_BYTE, 0, 32'h301, 32'h0, 32'h12348056, 0);
    check("lb_lv", 0, lv_w[0], 1);
    check("lb_data", 0, ld_w[0], 32'hFFFFFF80);
    check("lb_be", 0, snap_be, 4'b0010);
    check("lb_wdata", 0, snap_wdata, 32'h0);

    access(0, 1, SZ_BYTE, 1, 32'h301, 32'h0, 32'h12348056, 0);
    check("lbu_data", 0, ld_w[0], 32'h00000080);

    e1 = err_cnt[1];
    access(0, 1, SZ_HALF, 0, 32'h402, 32'h0, 32'h9ABC0000, 5);
    check("lh_data", 0, ld_w[0], 32'hFFFF9ABC);
    check("lh_stalls", 0, stalls, 7);
    check("lh_be", 0, snap_be, 4'b1100);
    check("lh_t4_err", 1, err_cnt[1] - e1, 1);

    // Ready never arrives within inst1's window; inst0 finishes later.
    e0 = err_cnt[0]; e1 = err_cnt[1]; l1 = lv_cnt[1];
    access(0, 1, SZ_WORD, 0, 32'h500, 32'h0, 32'h11223344, 7);
    check("to_err", 1, err_cnt[1] - e1, 1);
    check("to_no_lv", 1, lv_cnt[1] - l1, 0);
    check("to_idle", 1, req_w[1], 0);
    check("to_long_ok", 0, ld_w[0], 32'h11223344);
    check("to_long_noerr", 0, err_cnt[0] - e0, 0);

    // Ready on the expiry cycle completes normally.
    e1 = err_cnt[1];
    access(0, 1, SZ_WORD, 0, 32'h504, 32'h0, 32'h55667788, 3);
    check("exp_lv", 1, lv_w[1], 1);
    check("exp_data", 1, ld_w[1], 32'h55667788);
    check("exp_noerr", 1, err_cnt[1] - e1, 0);

    // Dropped requests.
    s0 = stall_cnt[0];
    load_req_in = 1; misaligned_in = 1; addr_in = 32'h701;
    @(posedge clk); #1;
    load_req_in = 0; misaligned_in = 0;
    mem_wr_req_in = 1; flush_in = 1; addr_in = 32'h704;
    @(posedge clk); #1;
    mem_wr_req_in = 0; flush_in = 0;
    @(posedge clk); #1;
    check("drop_stall", 0, stall_cnt[0] - s0, 0);
    check("drop_req", 0, req_w[0], 0);

    // Both requests: store wins.
    access(1, 1, SZ_WORD, 0, 32'h600, 32'h12345678, 32'h0, 1);
    check("both_we", 0, snap_we, 1);
    check("both_no_lv", 0, lv_w[0], 0);

    // Ready while idle is ignored.
    l1 = lv_cnt[0];
    dmem_ready_in = 1; dmem_rdata_in = 32'hFFFFFFFF;
    repeat (2) begin @(posedge clk); #1; end
    dmem_ready_in = 0;
    @(posedge clk); #1;
    check("idle_ready", 0, lv_cnt[0] - l1, 0);

    // Back-to-back accesses.
    access(0, 1, SZ_HALF, 1, 32'h2, 32'h0, 32'h80017FFF, 0);
    check("b2b_half", 0, ld_w[0], 32'h00008001);
    access(0, 1, 2'b11, 0, 32'h4, 32'h0, 32'hCAFEF00D, 0);
    check("b2b_word", 0, ld_w[0], 32'hCAFEF00D);
    check("b2b_be", 0, snap_be, 4'b1111);

    // Reset in the middle of WAIT.
    load_req_in = 1; load_size_in = SZ_WORD; addr_in = 32'h800;
    @(posedge clk); #1;
    load_req_in = 0;
    @(posedge clk); #2;
    reset_in = 1;
    #1;
    for (int k = 0; k < N; k++) begin
      check("rst_mid_req", k, req_w[k], 0);
      check("rst_mid_stall", k, stall_w[k], 0);
    end
    @(posedge clk); #1;
    reset_in = 0;
    repeat (4) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
